frame_write_arbiter: RTL and testbench
======================================

Name: frame_write_arbiter

Overview:
- Shares the display driver's image-buffer write port (iWREN/iAddress/iImage) between two requesters: a streaming video source (linear raster, SOF-framed) and a host random-access port.
- Also owns the driver's iBrightness input and applies host brightness changes as a timed fade.
- Sits between the video/host logic and the drive block, in the iSysclk domain.

Parameters:
ADDR_W, 13, image-buffer address width
PIX_W, 30, pixel width ({R10,G10,B10})
IMG_WORDS, 7680, words per frame (240 rows x 32); row = addr[12:5]
FADE_DIV, 1024, iSysclk cycles per brightness step (>=2)
BRT_RESET, 8, brightness value after reset

Ports:
iSysclk  in  1  system clock
iReset  in  1  synchronous active-high reset
iVidValid  in  1  stream pixel valid
iVidSof  in  1  qualifies current beat as first pixel of a frame
iVidPixel  in  PIX_W  stream pixel
oVidReady  out  1  stream beat accepted when iVidValid&&oVidReady
iHostReq  in  1  host write request, held until oHostAck
iHostAddr  in  ADDR_W  host write address
iHostData  in  PIX_W  host write data
oHostAck  out  1  one-cycle pulse, coincident with the host write on oWREN
iBrtWr  in  1  load new brightness target
iBrtVal  in  4  brightness target
iErrClr  in  1  clears sticky error flags
oWREN  out  1  to drive.iWREN
oAddress  out  ADDR_W  to drive.iAddress
oImage  out  PIX_W  to drive.iImage
oBrightness  out  4  to drive.iBrightness
oFrameDone  out  1  one-cycle pulse after last word of a frame is written
oSofErr  out  1  sticky: SOF arrived mid-frame
oAddrErr  out  1  sticky: host address >= IMG_WORDS

Behaviour:
- Clock and reset: one clock, iSysclk. Reset is synchronous and active-high (iReset).
- Reset values: oWREN=0, oAddress=0, oImage=0, oHostAck=0, oFrameDone=0, oSofErr=0, oAddrErr=0, oBrightness=target=BRT_RESET, fade counter=0, stream FSM=WAIT_SOF, vid_addr=0, last_grant=HOST, host_hold=0.
- Reset mid-operation: a grant made in the reset cycle is dropped; oWREN=0 the following cycle.
- Write port: registered, 1-cycle latency from grant to oWREN/oAddress/oImage. At most one write per cycle. oAddress/oImage hold their last value when oWREN=0.
- Stream FSM, state WAIT_SOF:
  - oVidReady=1. Non-SOF beats are discarded (no write).
  - An accepted SOF beat is granted immediately (priority over host in this cycle only) and written at vid_addr=0; vid_addr<=1; state<=ACTIVE.
- Stream FSM, state ACTIVE:
  - Eligible when iVidValid. An accepted beat writes at vid_addr, then vid_addr++.
  - Beat written at IMG_WORDS-1: vid_addr<=0, state<=WAIT_SOF, oFrameDone pulses together with that write's oWREN.
  - Accepted SOF beat in ACTIVE: written at address 0, vid_addr<=1, stays ACTIVE, oSofErr<=1.
- Host eligibility: host eligible when iHostReq && !host_hold. host_hold=1 for the cycle after a host grant (the ack cycle), so host throughput is at most 1 write / 2 cycles and a held request is not re-granted.
- Arbitration (round-robin):
  - Both eligible: grant the side != last_grant.
  - One eligible: grant it.
  - Each grant updates last_grant.
  - oVidReady in ACTIVE = !(host eligible && last_grant==VID). It is combinational from iHostReq and host_hold.
- Host grant: the next cycle oHostAck=1.
  - If iHostAddr<IMG_WORDS: oWREN=1 with that address/data.
  - Otherwise: oWREN=0 and oAddrErr<=1 (ack still given).
- Brightness:
  - iBrtWr loads target<=iBrtVal and restarts the fade counter.
  - When oBrightness!=target, every FADE_DIV cycles oBrightness steps by ±1 toward target. When equal, the counter is idle at 0.
  - iBrtWr mid-fade retargets from the current value, with no jump.
- Errors: iErrClr clears oSofErr and oAddrErr. If an error event and iErrClr occur in the same cycle, set wins.

Decomposition:
- Shared package frame_pkg: ADDR_W, PIX_W, IMG_WORDS, BRT_W=4, stream FSM state encoding (WAIT_SOF, ACTIVE), grant encoding (VID, HOST).
- One natural sub-module: brightness_fader (target register, FADE_DIV counter, ±1 stepping), instantiated once. Arbiter, stream FSM and write register stay in the top.

Test Plan:
- Reset then a full frame with continuous valid, SOF on the first beat, no host -> 7680 writes, addresses 0..7679 on consecutive cycles; oFrameDone pulses with the write to 7679; FSM returns to WAIT_SOF.
- Continuous stream plus iHostReq held, addr 0x0100, data 0x3FFFFFFF -> host write appears within 2 cycles; oHostAck pulses once with oWREN and oAddress=0x0100; the stream stalls exactly one beat (oVidReady=0 one cycle); no stream address is skipped.
- Two stream beats without SOF in WAIT_SOF -> oVidReady=1, no oWREN. Next SOF beat -> write at address 0.
- SOF beat while vid_addr=100 -> write at address 0, next beat at 1, oSofErr=1 until iErrClr.
- Host address 7680 -> oHostAck=1, oWREN=0, oAddrErr=1. Host address 7679 -> normal write.
- FADE_DIV=4, BRT_RESET=8, iBrtWr value 11 -> oBrightness 9,10,11 at 4-cycle intervals. iBrtWr value 5 at oBrightness=10 -> steps down from 10 with no jump.
- iReset asserted in a grant cycle -> oWREN=0 next cycle, oBrightness=8.

Source files
------------

// File: rtl/frame_pkg.sv
// ---------------------------------------------------------------------------
// frame_pkg
// Shared definitions for the frame-buffer write arbiter slice: image-buffer
// geometry, brightness width, stream FSM state encoding and grant encoding.
// No ports (package).
// ---------------------------------------------------------------------------
package frame_pkg;

   localparam int ADDR_W    = 13;     // image-buffer address width
   localparam int PIX_W     = 30;     // {R10,G10,B10}
   localparam int IMG_WORDS = 7680;   // 240 rows x 32 words, row = addr[12:5]
   localparam int BRT_W     = 4;      // drive-block brightness width

   localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(IMG_WORDS - 1);

   typedef enum logic {
      WAIT_SOF = 1'b0,
      ACTIVE   = 1'b1
   } vid_state_t;

   typedef enum logic {
      VID  = 1'b0,
      HOST = 1'b1
   } grant_t;

   // True when a host address lands inside the visible frame.
   function automatic logic addr_in_frame(input logic [ADDR_W-1:0] addr);
      return addr <= LAST_ADDR;
   endfunction

endpackage

// File: rtl/brightness_fader.sv
// ---------------------------------------------------------------------------
// brightness_fader
// Holds the brightness target written by the host and walks the driven
// brightness toward it one step every FADE_DIV clocks, so a brightness change
// appears as a fade instead of a jump.
//
// Ports:
//   iSysclk      system clock
//   iReset       synchronous active-high reset
//   iBrtWr       load a new target (restarts the step timer)
//   iBrtVal      new brightness target
//   oBrightness  brightness presented to the drive block
// ---------------------------------------------------------------------------
module brightness_fader
   import frame_pkg::*;
#(
   parameter int               FADE_DIV  = 1024,
   parameter logic [BRT_W-1:0] BRT_RESET = 4'd8
) (
   input  logic             iSysclk,
   input  logic             iReset,
   input  logic             iBrtWr,
   input  logic [BRT_W-1:0] iBrtVal,
   output logic [BRT_W-1:0] oBrightness
);

   localparam int               CNT_W    = $clog2(FADE_DIV);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FADE_DIV - 1);

   logic [BRT_W-1:0] target;
   logic [CNT_W-1:0] fade_cnt;

   // One unit toward the target; never overshoots.
   function automatic logic [BRT_W-1:0] step_toward(input logic [BRT_W-1:0] cur,
                                                    input logic [BRT_W-1:0] tgt);
      if (tgt > cur)
         return cur + BRT_W'(1);
      else if (tgt < cur)
         return cur - BRT_W'(1);
      return cur;
   endfunction

   // A retarget keeps the current brightness and only restarts the timer,
   // so a mid-fade write never causes a visible jump.
   always_ff @(posedge iSysclk) begin
      if (iReset) begin
         target      <= BRT_RESET;
         oBrightness <= BRT_RESET;
         fade_cnt    <= '0;
      end else if (iBrtWr) begin
         target   <= iBrtVal;
         fade_cnt <= '0;
      end else if (oBrightness != target) begin
         if (fade_cnt == CNT_LAST) begin
            oBrightness <= step_toward(oBrightness, target);
            fade_cnt    <= '0;
         end else begin
            fade_cnt <= fade_cnt + CNT_W'(1);
         end
      end else begin
         fade_cnt <= '0;
      end
   end

endmodule

// File: rtl/frame_write_arbiter.sv
// ---------------------------------------------------------------------------
// frame_write_arbiter
// Shares the drive block's image-buffer write port between a SOF-framed
// raster video stream and a host random-access write port (round-robin), and
// owns the drive block's brightness input via a fader.
//
// Ports:
//   iSysclk, iReset              clock, synchronous active-high reset
//   iVidValid/iVidSof/iVidPixel  stream beat; oVidReady accepts it
//   iHostReq/iHostAddr/iHostData host write, held until oHostAck
//   oHostAck                     1-cycle pulse alongside the host write
//   iBrtWr/iBrtVal               new brightness target
//   iErrClr                      clears the sticky error flags
//   oWREN/oAddress/oImage        registered write port to the drive block
//   oBrightness                  brightness to the drive block
//   oFrameDone                   pulse with the write of the last frame word
//   oSofErr                      sticky: SOF arrived mid-frame
//   oAddrErr                     sticky: host address outside the frame
// ---------------------------------------------------------------------------
module frame_write_arbiter
   import frame_pkg::*;
#(
   parameter int               FADE_DIV  = 1024,
   parameter logic [BRT_W-1:0] BRT_RESET = 4'd8
) (
   input  logic              iSysclk,
   input  logic              iReset,
   input  logic              iVidValid,
   input  logic              iVidSof,
   input  logic [PIX_W-1:0]  iVidPixel,
   output logic              oVidReady,
   input  logic              iHostReq,
   input  logic [ADDR_W-1:0] iHostAddr,
   input  logic [PIX_W-1:0]  iHostData,
   output logic              oHostAck,
   input  logic              iBrtWr,
   input  logic [BRT_W-1:0]  iBrtVal,
   input  logic              iErrClr,
   output logic              oWREN,
   output logic [ADDR_W-1:0] oAddress,
   output logic [PIX_W-1:0]  oImage,
   output logic [BRT_W-1:0]  oBrightness,
   output logic              oFrameDone,
   output logic              oSofErr,
   output logic              oAddrErr
);

   vid_state_t        state, state_nxt;
   logic [ADDR_W-1:0] vid_addr, vid_addr_nxt;
   grant_t            last_grant;
   logic              host_hold;

   logic              host_elig_p0;
   logic              vid_rdy_p0;
   logic              gnt_vid_p0;
   logic              gnt_host_p0;
   logic              host_ok_p0;
   logic              vld_p0;
   logic [ADDR_W-1:0] addr_p0;
   logic [PIX_W-1:0]  data_p0;
   logic              done_p0;
   logic              sof_err_set_p0;
   logic              addr_err_set_p0;

   logic              vld_p1;
   logic              ack_p1;
   logic              done_p1;
   logic [ADDR_W-1:0] addr_p1;
   logic [PIX_W-1:0]  data_p1;
   logic              sof_err;
   logic              addr_err;

   // ---- stage p0: arbitration ----
   // While waiting for SOF every beat is taken (non-SOF beats are dropped)
   // and an SOF beat beats the host, so a frame start is never delayed.
   // In a frame the stream only backs off when the host is waiting and the
   // stream had the previous grant.
   always_comb begin
      host_elig_p0 = iHostReq && !host_hold;
      vid_rdy_p0   = 1'b1;
      gnt_vid_p0   = 1'b0;
      if (state == WAIT_SOF) begin
         gnt_vid_p0 = iVidValid && iVidSof;
      end else begin
         vid_rdy_p0 = !(host_elig_p0 && (last_grant == VID));
         gnt_vid_p0 = iVidValid && vid_rdy_p0;
      end
      gnt_host_p0 = host_elig_p0 && !gnt_vid_p0;
   end

   // Stream FSM next state and raster address.
   always_comb begin
      state_nxt      = state;
      vid_addr_nxt   = vid_addr;
      done_p0        = 1'b0;
      sof_err_set_p0 = 1'b0;
      if (gnt_vid_p0) begin
         if (iVidSof) begin
            // SOF always restarts the raster; mid-frame it is also an error.
            vid_addr_nxt   = ADDR_W'(1);
            state_nxt      = ACTIVE;
            sof_err_set_p0 = (state == ACTIVE);
         end else if (vid_addr == LAST_ADDR) begin
            vid_addr_nxt = '0;
            state_nxt    = WAIT_SOF;
            done_p0      = 1'b1;
         end else begin
            vid_addr_nxt = vid_addr + ADDR_W'(1);
         end
      end
   end

   // Write-port source select. An out-of-frame host write is acked but
   // suppressed on the write port.
   always_comb begin
      host_ok_p0      = addr_in_frame(iHostAddr);
      vld_p0          = 1'b0;
      addr_p0         = vid_addr;
      data_p0         = iVidPixel;
      addr_err_set_p0 = 1'b0;
      if (gnt_vid_p0) begin
         vld_p0  = 1'b1;
         addr_p0 = iVidSof ? '0 : vid_addr;
      end else if (gnt_host_p0) begin
         vld_p0          = host_ok_p0;
         addr_p0         = iHostAddr;
         data_p0         = iHostData;
         addr_err_set_p0 = !host_ok_p0;
      end
   end

   always_ff @(posedge iSysclk) begin
      if (iReset) begin
         state      <= WAIT_SOF;
         vid_addr   <= '0;
         last_grant <= HOST;
         host_hold  <= 1'b0;
      end else begin
         state     <= state_nxt;
         vid_addr  <= vid_addr_nxt;
         // Blocks the same held request from being granted in its ack cycle.
         host_hold <= gnt_host_p0;
         if (gnt_vid_p0)
            last_grant <= VID;
         else if (gnt_host_p0)
            last_grant <= HOST;
      end
   end

   // ---- stage p1: registered write port and status ----
   // Address/data only move on a real write so they hold between writes.
   always_ff @(posedge iSysclk) begin
      if (iReset) begin
         vld_p1   <= 1'b0;
         ack_p1   <= 1'b0;
         done_p1  <= 1'b0;
         addr_p1  <= '0;
         data_p1  <= '0;
         sof_err  <= 1'b0;
         addr_err <= 1'b0;
      end else begin
         vld_p1  <= vld_p0;
         ack_p1  <= gnt_host_p0;
         done_p1 <= done_p0;
         if (vld_p0) begin
            addr_p1 <= addr_p0;
            data_p1 <= data_p0;
         end
         // A new error in the clear cycle still sets the flag.
         sof_err  <= sof_err_set_p0  || (sof_err  && !iErrClr);
         addr_err <= addr_err_set_p0 || (addr_err && !iErrClr);
      end
   end

   brightness_fader #(
      .FADE_DIV  (FADE_DIV),
      .BRT_RESET (BRT_RESET)
   ) u_fader (
      .iSysclk     (iSysclk),
      .iReset      (iReset),
      .iBrtWr      (iBrtWr),
      .iBrtVal     (iBrtVal),
      .oBrightness (oBrightness)
   );

   assign oVidReady  = vid_rdy_p0;
   assign oWREN      = vld_p1;
   assign oAddress   = addr_p1;
   assign oImage     = data_p1;
   assign oHostAck   = ack_p1;
   assign oFrameDone = done_p1;
   assign oSofErr    = sof_err;
   assign oAddrErr   = addr_err;

endmodule

// File: tb/tb_frame_write_arbiter.sv
// ---------------------------------------------------------------------------
// tb_frame_write_arbiter
// Scoreboard bench: the stimulus side runs a behavioural model of the
// arbiter's rules and queues the expected write-port events and per-cycle
// status; a monitor pops and compares them against the DUT outputs.
// ---------------------------------------------------------------------------
module tb_frame_write_arbiter;
   import frame_pkg::*;

   localparam int         FD = 4;
   localparam logic [3:0] BR = 4'd8;

   logic              clk = 1'b0;
   logic              rst, vv, vsof, vrdy, hreq, hack, brtwr, errclr;
   logic [PIX_W-1:0]  vpix, hdata, img;
   logic [ADDR_W-1:0] haddr, addr;
   logic [3:0]        brtval, brt;
   logic              wren, fdone, soferr, adderr;

   always #5 clk = ~clk;

   frame_write_arbiter #(.FADE_DIV(FD), .BRT_RESET(BR)) dut (
      .iSysclk(clk), .iReset(rst),
      .iVidValid(vv), .iVidSof(vsof), .iVidPixel(vpix), .oVidReady(vrdy),
      .iHostReq(hreq), .iHostAddr(haddr), .iHostData(hdata), .oHostAck(hack),
      .iBrtWr(brtwr), .iBrtVal(brtval), .iErrClr(errclr),
      .oWREN(wren), .oAddress(addr), .oImage(img), .oBrightness(brt),
      .oFrameDone(fdone), .oSofErr(soferr), .oAddrErr(adderr)
   );

   typedef struct {
      int                cyc;
      logic              wr;
      logic [ADDR_W-1:0] a;
      logic [PIX_W-1:0]  d;
      logic              ack;
   } wr_t;

   typedef struct {
      logic       fd;
      logic       se;
      logic       ae;
      logic [3:0] b;
   } st_t;

   wr_t wq[$];
   st_t sq[$];
   int  checks   = 0;
   int  failures = 0;
   int  cyc      = 0;

   always @(posedge clk) cyc <= cyc + 1;

   // Reference model state: frame position, who went last, host ack cycle,
   // sticky flags, brightness fade.
   bit m_in_frame, m_last_vid, m_hold, m_se, m_ae;
   int m_pos, m_cur, m_tgt, m_tmr;

   // Applies the current inputs for one clock: checks ready, predicts the
   // outcome and queues it, then returns shortly after the clock edge.
   task automatic tick(output bit vcons, output bit hacc);
      bit  he, rdy, vacc, se_set, ae_set;
      wr_t w;
      st_t s;
      @(negedge clk);
      vcons = 0; hacc = 0; vacc = 0; se_set = 0; ae_set = 0; s.fd = 0;
      he  = hreq && !m_hold;
      rdy = m_in_frame ? !(he && m_last_vid) : 1'b1;
      if (rst) begin
         m_in_frame = 0; m_pos = 0; m_last_vid = 0; m_hold = 0;
         m_se = 0; m_ae = 0; m_cur = BR; m_tgt = BR; m_tmr = 0;
      end else begin
         checks++;
         if (vrdy !== rdy) begin
            failures++;
            $display("FAIL vid_ready cyc=%0d got=%b exp=%b", cyc, vrdy, rdy);
         end
         vcons = vv && rdy;
         vacc  = vv && (m_in_frame ? rdy : vsof);
         hacc  = he && !vacc;
         if (vacc) begin
            w.cyc = cyc + 1; w.wr = 1; w.d = vpix; w.ack = 0;
            if (vsof) begin
               se_set = m_in_frame;
               w.a = '0; m_pos = 1; m_in_frame = 1;
            end else begin
               w.a = ADDR_W'(m_pos);
               if (m_pos == IMG_WORDS - 1) begin
                  s.fd = 1; m_pos = 0; m_in_frame = 0;
               end else begin
                  m_pos++;
               end
            end
            wq.push_back(w);
            m_last_vid = 1;
         end
         if (hacc) begin
            w.cyc = cyc + 1; w.ack = 1;
            if (int'(haddr) < IMG_WORDS) begin
               w.wr = 1; w.a = haddr; w.d = hdata;
            end else begin
               w.wr = 0; w.a = '0; w.d = '0; ae_set = 1;
            end
            wq.push_back(w);
            m_last_vid = 0;
         end
         m_hold = hacc;
         m_se = se_set || (m_se && !errclr);
         m_ae = ae_set || (m_ae && !errclr);
         if (brtwr) begin
            m_tgt = int'(brtval); m_tmr = 0;
         end else if (m_cur != m_tgt) begin
            m_tmr++;
            if (m_tmr == FD) begin
               m_cur = (m_tgt > m_cur) ? m_cur + 1 : m_cur - 1;
               m_tmr = 0;
            end
         end else begin
            m_tmr = 0;
         end
      end
      s.se = m_se; s.ae = m_ae; s.b = 4'(m_cur);
      sq.push_back(s);
      @(posedge clk);
      #2;
   endtask

   // Randomised traffic; a stream beat and a host request are each held
   // until the model says they were taken. Percentages / permille knobs.
   task automatic run(input int n, input int pv, input int sofw, input int psof,
                      input int ph, input int pbad, input int pbrt, input int pclr);
      bit vc, hc;
      for (int i = 0; i < n; i++) begin
         if (!vv && $urandom_range(99) < pv) begin
            vv   = 1;
            vpix = PIX_W'($urandom);
            vsof = (!m_in_frame && $urandom_range(99) < sofw) || ($urandom_range(999) < psof);
         end
         if (!hreq && $urandom_range(99) < ph) begin
            hreq  = 1;
            haddr = ($urandom_range(99) < pbad) ? ADDR_W'($urandom_range(8191, IMG_WORDS))
                                                : ADDR_W'($urandom_range(IMG_WORDS - 1));
            hdata = PIX_W'($urandom);
         end
         brtwr  = ($urandom_range(999) < pbrt);
         brtval = 4'($urandom);
         errclr = ($urandom_range(99) < pclr);
         tick(vc, hc);
         if (vc) vv = 0;
         if (hc) hreq = 0;
      end
      brtwr = 0; errclr = 0;
   endtask

   // Monitor: per-cycle status, plus a write-port event whenever the DUT
   // shows a write or an ack.
   initial begin
      wr_t w;
      st_t s;
      forever begin
         @(posedge clk);
         #1;
         if (sq.size() > 0) begin
            s = sq.pop_front();
            checks++;
            if ({fdone, soferr, adderr, brt} !== {s.fd, s.se, s.ae, s.b}) begin
               failures++;
               $display("FAIL status cyc=%0d got fd=%b se=%b ae=%b brt=%0d exp fd=%b se=%b ae=%b brt=%0d",
                        cyc, fdone, soferr, adderr, brt, s.fd, s.se, s.ae, s.b);
            end
         end
         if (wren === 1'b1 || hack === 1'b1) begin
            checks++;
            if (wq.size() == 0) begin
               failures++;
               $display("FAIL unexpected_write cyc=%0d got wren=%b ack=%b addr=%0d exp none",
                        cyc, wren, hack, addr);
            end else begin
               w = wq.pop_front();
               if (w.cyc != cyc || wren !== w.wr || hack !== w.ack ||
                   (w.wr && (addr !== w.a || img !== w.d))) begin
                  failures++;
                  $display("FAIL write cyc=%0d got wren=%b ack=%b addr=%0d data=%h exp cyc=%0d wren=%b ack=%b addr=%0d data=%h",
                           cyc, wren, hack, addr, img, w.cyc, w.wr, w.ack, w.a, w.d);
               end
            end
         end
      end
   end

   initial begin
      #5_000_000;
      $display("FAIL watchdog cyc=%0d required finish before timeout", cyc);
      $fatal(1, "watchdog expired");
   end

   initial begin
      bit vc, hc;
      rst = 1; vv = 0; vsof = 0; vpix = '0; hreq = 0; haddr = '0; hdata = '0;
      brtwr = 0; brtval = '0; errclr = 0;
      tick(vc, hc);
      tick(vc, hc);
      rst = 0;

      // Full frame, continuous valid, SOF on the first beat, no host.
      run(IMG_WORDS, 100, 100, 0, 0, 0, 0, 0);
      // Two non-SOF beats while waiting for SOF, then an SOF beat.
      run(2, 100, 0, 0, 0, 0, 0, 0);
      run(1, 100, 100, 0, 0, 0, 0, 0);
      // Host write held against a continuous stream.
      hreq = 1; haddr = ADDR_W'(13'h0100); hdata = PIX_W'(30'h3FFF_FFFF);
      run(20, 100, 0, 0, 0, 0, 0, 0);
      // SOF arriving with the raster at address 100, then error clear.
      for (int k = 0; k < 8000 && m_pos != 100; k++) run(1, 100, 0, 0, 0, 0, 0, 0);
      vv = 1; vsof = 1; vpix = PIX_W'($urandom);
      run(6, 100, 0, 0, 0, 0, 0, 0);
      run(3, 100, 0, 0, 0, 0, 0, 100);
      // Host addresses just past and at the end of the frame.
      hreq = 1; haddr = ADDR_W'(IMG_WORDS); hdata = PIX_W'($urandom);
      run(3, 0, 0, 0, 0, 0, 0, 0);
      hreq = 1; haddr = ADDR_W'(IMG_WORDS - 1); hdata = PIX_W'($urandom);
      run(3, 0, 0, 0, 0, 0, 0, 0);
      // Fade 8 -> 11, retarget to 5 once the value reaches 10.
      brtwr = 1; brtval = 4'd11;
      tick(vc, hc);
      brtwr = 0;
      run(8, 0, 0, 0, 0, 0, 0, 0);
      brtwr = 1; brtval = 4'd5;
      tick(vc, hc);
      brtwr = 0;
      run(30, 0, 0, 0, 0, 0, 0, 0);
      // Reset in a cycle where both sides want a grant.
      vv = 1; vsof = 1; hreq = 1; haddr = ADDR_W'(5); hdata = PIX_W'($urandom);
      rst = 1;
      tick(vc, hc);
      rst = 0;
      run(10, 50, 50, 0, 50, 0, 0, 0);
      // Random mixes.
      run(3000, 70, 50, 5, 40, 10, 5, 5);
      run(3000, 95, 80, 2, 90, 20, 3, 3);
      vv = 0; hreq = 0;
      run(4, 0, 0, 0, 0, 0, 0, 0);

      checks++;
      if (wq.size() != 0) begin
         failures++;
         $display("FAIL pending_writes got=%0d exp=0", wq.size());
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
